// File: rtl/norm_iter.sv
// Iterative post-adder normaliser: corrects a one-bit carry overflow with a single
// right shift, or removes leading zeros one bit per cycle, with a valid/ready handshake.
module norm_iter #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mantissa_i,
  input  logic [EXP_W-1:0]  exponent_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mantissa,
  output logic [EXP_W-1:0]  exponent,
  output logic              zero,
  output logic              ovf,
  output logic              uf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0]  EXP_MAX    = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  EXP_MAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0]  EXP_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0]  EXP_ZERO   = {EXP_W{1'b0}};
  localparam logic [MANT_W-1:0] MANT_ZERO  = {MANT_W{1'b0}};

  state_t             state_q, state_d;
  logic [MANT_W-1:0]  m_q, m_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic [MANT_W-1:0]  mantissa_q, mantissa_d;
  logic [EXP_W-1:0]   exponent_q, exponent_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               uf_q, uf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  // Next-state, working-register and result computation.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    mantissa_d  = mantissa_q;
    exponent_d  = exponent_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    uf_d        = uf_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = mantissa_i;
          e_d     = exponent_i;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_NORM: begin
        if (m_q == MANT_ZERO) begin
          mantissa_d = MANT_ZERO;
          exponent_d = EXP_ZERO;
          zero_d     = 1'b1;
          state_d    = ST_DONE;
        end else if (m_q[MANT_W-1] && (e_q >= EXP_MAX_M1)) begin
          // Incrementing would reach or pass EXP_MAX: saturate instead of wrapping.
          mantissa_d = MANT_ZERO;
          exponent_d = EXP_MAX;
          ovf_d      = 1'b1;
          state_d    = ST_DONE;
        end else if (m_q[MANT_W-1]) begin
          mantissa_d = m_q >> 1;
          exponent_d = e_q + EXP_ONE;
          state_d    = ST_DONE;
        end else if (m_q[MANT_W-2]) begin
          mantissa_d = m_q;
          exponent_d = e_q;
          state_d    = ST_DONE;
        end else if (e_q == EXP_ZERO) begin
          mantissa_d = m_q;
          exponent_d = EXP_ZERO;
          uf_d       = 1'b1;
          state_d    = ST_DONE;
        end else begin
          m_d     = m_q << 1;
          e_d     = e_q - EXP_ONE;
          state_d = ST_NORM;
        end
      end

      ST_DONE: begin
        // out_valid lags entry into DONE by one cycle; the result is retired only
        // once it has actually been presented.
        if (out_valid_q && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // State, working and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      m_q         <= MANT_ZERO;
      e_q         <= EXP_ZERO;
      mantissa_q  <= MANT_ZERO;
      exponent_q  <= EXP_ZERO;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      uf_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      mantissa_q  <= mantissa_d;
      exponent_q  <= exponent_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      uf_q        <= uf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mantissa  = mantissa_q;
  assign exponent  = exponent_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign uf        = uf_q;

endmodule
